sw_array_ctrl: RTL

- Sequencer for the Smith-Waterman systolic PE array.
- Accepts a job of query length plus target length, streams target characters into PE 0 and times the wavefront drain.
- Tracks the running best local score reported by the array and returns one score per job over a valid/ready handshake.
- Sits between the host-side stream interface and the PE chain; the query is preloaded into the PEs separately.

---
 rtl/sw_array_ctrl_if.sv | 47 ++++
 rtl/sw_array_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/sw_array_ctrl_if.sv
// rtl/sw_array_ctrl_if.sv - job, target-stream, PE-array and score signals of the Smith-Waterman sequencer
// best_pos is present only when SW_BEST_POS_EN is defined.
interface sw_array_ctrl_if #(
  parameter int LEN_BIT  = 16,
  parameter int CHAR_BIT = 2,
  parameter int VBIT     = 16
);
  logic                start;
  logic [LEN_BIT-1:0]  query_len;
  logic [LEN_BIT-1:0]  target_len;
  logic                busy;
  logic                len_err;
  logic                tgt_valid;
  logic [CHAR_BIT-1:0] tgt_char;
  logic                tgt_ready;
  logic                pe_t_valid;
  logic [CHAR_BIT-1:0] pe_t_char;
  logic                pe_clear;
  logic                pe_max_valid;
  logic [VBIT-1:0]     pe_max_v;
  logic                score_valid;
  logic [VBIT-1:0]     score;
  logic                score_ready;
`ifdef SW_BEST_POS_EN
  logic [LEN_BIT-1:0]  best_pos;
`endif

  modport master (
`ifdef SW_BEST_POS_EN
    input  best_pos,
`endif
    output start, query_len, target_len, tgt_valid, tgt_char,
    output pe_max_valid, pe_max_v, score_ready,
    input  busy, len_err, tgt_ready, pe_t_valid, pe_t_char, pe_clear,
    input  score_valid, score
  );

  modport slave (
`ifdef SW_BEST_POS_EN
    output best_pos,
`endif
    input  start, query_len, target_len, tgt_valid, tgt_char,
    input  pe_max_valid, pe_max_v, score_ready,
    output busy, len_err, tgt_ready, pe_t_valid, pe_t_char, pe_clear,
    output score_valid, score
  );
endinterface

// File: rtl/sw_array_ctrl.sv
// rtl/sw_array_ctrl.sv - Smith-Waterman systolic array sequencer: target streaming, drain timing, best-score tracking
// Optional macro SW_BEST_POS_EN adds best_pos (target position of the best score).
module sw_array_ctrl #(
  parameter int PE_NUM   = 64,
  parameter int LEN_BIT  = 16,
  parameter int CHAR_BIT = 2,
  parameter int VBIT     = 16,
  parameter int PE_LAT   = 2
) (
  input  logic            clk,
  input  logic            rst,
  sw_array_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  localparam logic [LEN_BIT-1:0] PE_NUM_L = LEN_BIT'(PE_NUM);
  localparam logic [LEN_BIT-1:0] PE_LAT_L = LEN_BIT'(PE_LAT);

  state_t              state, state_nxt;
  logic [LEN_BIT-1:0]  qlen, tlen, char_cnt, drain_cnt;
  logic [VBIT-1:0]     best;
  logic                len_err_q, pe_t_valid_q;
  logic [CHAR_BIT-1:0] pe_t_char_q;
  logic                legal, accept, xfer, last, track, better;

  // Sign-magnitude style ordering shared with the PE array's max tree.
  function automatic logic beats(input logic [VBIT-1:0] a, input logic [VBIT-1:0] b);
    if (a[VBIT-1] != b[VBIT-1]) return !a[VBIT-1];
    else if (!a[VBIT-1])        return a[VBIT-2:0] > b[VBIT-2:0];
    else                        return a[VBIT-2:0] < b[VBIT-2:0];
  endfunction

  always_comb begin
    legal  = (bus.query_len != '0) && (bus.query_len <= PE_NUM_L) && (bus.target_len != '0);
    accept = (state == IDLE) && bus.start && legal;
    xfer   = (state == RUN) && bus.tgt_valid;
    last   = xfer && (char_cnt + 1'b1 == tlen);
    track  = ((state == RUN) || (state == DRAIN)) && bus.pe_max_valid;
    better = track && beats(bus.pe_max_v, best);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CLEAR;
      CLEAR:   state_nxt = RUN;
      RUN:     if (last) state_nxt = DRAIN;
      // Leaves as the count reaches zero, giving query_len+PE_LAT drain cycles.
      DRAIN:   if (drain_cnt == LEN_BIT'(1)) state_nxt = DONE;
      DONE:    if (bus.score_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      qlen         <= '0;
      tlen         <= '0;
      char_cnt     <= '0;
      drain_cnt    <= '0;
      best         <= '0;
      len_err_q    <= 1'b0;
      pe_t_valid_q <= 1'b0;
      pe_t_char_q  <= '0;
    end else begin
      state        <= state_nxt;
      len_err_q    <= (state == IDLE) && bus.start && !legal;
      pe_t_valid_q <= xfer;
      if (accept) begin
        qlen     <= bus.query_len;
        tlen     <= bus.target_len;
        char_cnt <= '0;
        best     <= '0;
      end
      if (xfer) begin
        pe_t_char_q <= bus.tgt_char;
        char_cnt    <= char_cnt + 1'b1;
      end
      if (last)                drain_cnt <= qlen + PE_LAT_L;
      else if (state == DRAIN) drain_cnt <= drain_cnt - 1'b1;
      if (better) best <= bus.pe_max_v;
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.len_err     = len_err_q;
  assign bus.tgt_ready   = (state == RUN);
  assign bus.pe_t_valid  = pe_t_valid_q;
  assign bus.pe_t_char   = pe_t_char_q;
  assign bus.pe_clear    = (state == CLEAR);
  assign bus.score_valid = (state == DONE);
  assign bus.score       = best;

`ifdef SW_BEST_POS_EN
  localparam logic signed [LEN_BIT+1:0] LAT_S = (LEN_BIT+2)'(PE_LAT);
  localparam logic signed [LEN_BIT+1:0] ONE_S = (LEN_BIT+2)'(1);

  logic [LEN_BIT-1:0]        pos_cnt, pos_nxt, pos_clamped, best_pos_q;
  logic                      pos_step;
  logic signed [LEN_BIT+1:0] pos_raw, tlen_s;

  // The wavefront keeps advancing through DRAIN, so the position counter does too.
  always_comb begin
    pos_step = xfer || (state == DRAIN);
    pos_nxt  = pos_cnt + {{(LEN_BIT-1){1'b0}}, pos_step};
    pos_raw  = $signed({2'b00, pos_nxt}) - LAT_S;
    tlen_s   = $signed({2'b00, tlen});
    if (pos_raw < ONE_S)       pos_clamped = LEN_BIT'(1);
    else if (pos_raw > tlen_s) pos_clamped = tlen;
    else                       pos_clamped = pos_raw[LEN_BIT-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_cnt    <= '0;
      best_pos_q <= '0;
    end else if (accept) begin
      pos_cnt    <= '0;
      best_pos_q <= '0;
    end else begin
      if (pos_step) pos_cnt <= pos_nxt;
      if (better)   best_pos_q <= pos_clamped;
    end
  end

  assign bus.best_pos = best_pos_q;
`endif
endmodule
